// File: rtl/reader_pkg.sv
// Shared definitions for the reader core: opcode values, FSM state encoding
// and the layout of the debug word.
package reader_pkg;

  // FSM state; the encoding is visible to observers in debug[31:24]
  typedef enum logic [7:0] {
    ST_IDLE   = 8'd0,
    ST_FETCH  = 8'd1,
    ST_EXEC   = 8'd2,
    ST_MEM    = 8'd3,
    ST_HALTED = 8'd4
  } state_e;

  // Opcode byte values (low byte of the fetched word)
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOVC = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_LOAD = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h05;
  localparam logic [7:0] OP_JZ   = 8'h06;
  localparam logic [7:0] OP_HALT = 8'h07;

  // Instruction lengths in bytes: one-byte forms and three-byte forms
  localparam logic [7:0] IP_STEP_SHORT = 8'd1;
  localparam logic [7:0] IP_STEP_LONG  = 8'd3;

  // Debug word: {state, 8'h00, last unknown opcode, retired count}
  function automatic logic [31:0] packDebug(input logic [7:0] stateCode,
                                            input logic [7:0] unknownOp,
                                            input logic [7:0] retired);
    return {stateCode, 8'h00, unknownOp, retired};
  endfunction

endpackage

// File: rtl/reader_mem_port.sv
// Read-port handshake for the reader core. A request is raised by a start
// pulse, the ack must be seen low at least once while the request is up
// (arming) before a high ack is accepted, so a stale or X ack never counts.
module reader_mem_port (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic       readAck_i,
  output logic       readReq_o,
  output logic [7:0] ramAddress_o,
  output logic       accept_o
);

  logic       reqQ = 1'b0;
  logic       armedQ = 1'b0;
  logic [7:0] addrQ = 8'h00;
  logic       reqD;
  logic       armedD;
  logic [7:0] addrD;

  // Accept only an explicit 1 on ack while an armed request is outstanding
  always_comb begin
    accept_o = 1'b0;
    if (reqQ && armedQ && (readAck_i == 1'b1)) begin
      accept_o = 1'b1;
    end
  end

  // Next request/armed/address: start wins, then accept, then arming on ack low
  always_comb begin
    reqD   = reqQ;
    armedD = armedQ;
    addrD  = addrQ;
    if (start_i) begin
      reqD   = 1'b1;
      armedD = 1'b0;
      addrD  = addr_i;
    end else if (accept_o) begin
      reqD   = 1'b0;
      armedD = 1'b0;
    end else if (reqQ && (readAck_i == 1'b0)) begin
      armedD = 1'b1;
    end
  end

  // Handshake registers; reset drops any outstanding request immediately
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      reqQ   <= 1'b0;
      armedQ <= 1'b0;
      addrQ  <= 8'h00;
    end else begin
      reqQ   <= reqD;
      armedQ <= armedD;
      addrQ  <= addrD;
    end
  end

  assign readReq_o    = reqQ;
  assign ramAddress_o = addrQ;

endmodule

// File: rtl/reader.sv
// reader: minimal 8-bit-address accumulator-style core. Fetches a 32-bit
// little-endian word per instruction, executes it in one cycle, and uses a
// second memory read for LOAD. Two 32-bit registers, HALT is terminal.
module reader
  import reader_pkg::*;
(
  output logic [7:0]  iPointer,
  output logic [7:0]  opCode,
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] debug,
  output logic [7:0]  ramAddress,
  input  logic [31:0] ramValue,
  output logic        readReq,
  input  logic        readAck
);

  state_e      stateQ = ST_IDLE;
  logic [7:0]  ipQ = 8'h00;
  logic [7:0]  opQ = 8'h00;
  logic [7:0]  aQ = 8'h00;
  logic [7:0]  bQ = 8'h00;
  logic [31:0] r0Q = 32'h0;
  logic [31:0] r1Q = 32'h0;
  logic [7:0]  unknownQ = 8'h00;
  logic [7:0]  retiredQ = 8'h00;

  state_e      stateD;
  logic [7:0]  ipD;
  logic [7:0]  opD;
  logic [7:0]  aD;
  logic [7:0]  bD;
  logic [31:0] r0D;
  logic [31:0] r1D;
  logic [7:0]  unknownD;
  logic [7:0]  retiredD;

  logic        portStart;
  logic [7:0]  portAddr;
  logic        portAccept;

  logic        regWe;
  logic        regSel;
  logic [31:0] regData;
  logic [31:0] srcA;
  logic [31:0] srcB;

  assign srcA = aQ[0] ? r1Q : r0Q;
  assign srcB = bQ[0] ? r1Q : r0Q;

  reader_mem_port uMemPort (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (portStart),
    .addr_i       (portAddr),
    .readAck_i    (readAck),
    .readReq_o    (readReq),
    .ramAddress_o (ramAddress),
    .accept_o     (portAccept)
  );

  // Next-state, register writeback and request control for every FSM state
  always_comb begin
    stateD    = stateQ;
    ipD       = ipQ;
    opD       = opQ;
    aD        = aQ;
    bD        = bQ;
    r0D       = r0Q;
    r1D       = r1Q;
    unknownD  = unknownQ;
    retiredD  = retiredQ;
    portStart = 1'b0;
    portAddr  = ipQ;
    regWe     = 1'b0;
    regSel    = aQ[0];
    regData   = 32'h0;

    case (stateQ)
      ST_IDLE: begin
        stateD = ST_FETCH;
      end

      ST_FETCH: begin
        portAddr = ipQ;
        if (!readReq) begin
          portStart = 1'b1;
        end else if (portAccept) begin
          opD    = ramValue[7:0];
          aD     = ramValue[15:8];
          bD     = ramValue[23:16];
          stateD = ST_EXEC;
        end
      end

      ST_EXEC: begin
        retiredD = retiredQ + 8'd1;
        stateD   = ST_FETCH;
        case (opQ)
          OP_NOP: begin
            ipD = ipQ + IP_STEP_SHORT;
          end
          OP_MOVC: begin
            regWe   = 1'b1;
            regData = {24'h0, bQ};
            ipD     = ipQ + IP_STEP_LONG;
          end
          OP_MOV: begin
            regWe   = 1'b1;
            regData = srcB;
            ipD     = ipQ + IP_STEP_LONG;
          end
          OP_ADD: begin
            regWe   = 1'b1;
            regData = srcA + srcB;
            ipD     = ipQ + IP_STEP_LONG;
          end
          OP_LOAD: begin
            stateD = ST_MEM;
          end
          OP_JMP: begin
            ipD = aQ;
          end
          OP_JZ: begin
            ipD = (srcA == 32'h0) ? bQ : (ipQ + IP_STEP_LONG);
          end
          OP_HALT: begin
            stateD = ST_HALTED;
          end
          default: begin
            ipD      = ipQ + IP_STEP_SHORT;
            unknownD = opQ;
          end
        endcase
      end

      ST_MEM: begin
        portAddr = bQ;
        if (!readReq) begin
          portStart = 1'b1;
        end else if (portAccept) begin
          regWe   = 1'b1;
          regData = ramValue;
          ipD     = ipQ + IP_STEP_LONG;
          stateD  = ST_FETCH;
        end
      end

      ST_HALTED: begin
        stateD = ST_HALTED;
      end

      default: begin
        stateD = ST_IDLE;
      end
    endcase

    if (regWe) begin
      if (regSel) begin
        r1D = regData;
      end else begin
        r0D = regData;
      end
    end
  end

  // Architectural state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= ST_IDLE;
      ipQ      <= 8'h00;
      opQ      <= 8'h00;
      aQ       <= 8'h00;
      bQ       <= 8'h00;
      r0Q      <= 32'h0;
      r1Q      <= 32'h0;
      unknownQ <= 8'h00;
      retiredQ <= 8'h00;
    end else begin
      stateQ   <= stateD;
      ipQ      <= ipD;
      opQ      <= opD;
      aQ       <= aD;
      bQ       <= bD;
      r0Q      <= r0D;
      r1Q      <= r1D;
      unknownQ <= unknownD;
      retiredQ <= retiredD;
    end
  end

  assign iPointer = ipQ;
  assign opCode   = opQ;
  assign r0       = r0Q;
  assign r1       = r1Q;
  assign debug    = packDebug(stateQ, unknownQ, retiredQ);

endmodule

// File: tb/tb_reader.sv
// Self-checking bench for reader: a byte memory with an ack responder,
// small programs run to HALT, and a scoreboard of expected end states.
module tb_reader;

  logic        clk;
  logic        reset;
  logic [7:0]  iPointer;
  logic [7:0]  opCode;
  logic [31:0] r0;
  logic [31:0] r1;
  logic [31:0] debug;
  logic [7:0]  ramAddress;
  logic [31:0] ramValue;
  logic        readReq;
  logic        readAck;

  logic [7:0]  mem [256];
  int          respMode;
  int          reqCount;
  int          vectors;
  int          miscompares;

  typedef struct {
    int          id;
    logic [7:0]  ip;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [7:0]  retired;
    logic [7:0]  unknown;
    int          cycles;
  } expect_t;

  expect_t sb [$];

  reader dut (
    .iPointer   (iPointer),
    .opCode     (opCode),
    .clk        (clk),
    .reset      (reset),
    .r0         (r0),
    .r1         (r1),
    .debug      (debug),
    .ramAddress (ramAddress),
    .ramValue   (ramValue),
    .readReq    (readReq),
    .readAck    (readAck)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: drops ack one edge after seeing a request, returns
  // data with ack high on the following edge; other modes hold ack at 1 or X
  initial begin
    logic [7:0] base;
    readAck  = 1'b0;
    ramValue = 32'h0;
    reqCount = 0;
    forever begin
      @(posedge clk);
      #1;
      if (respMode == 1) begin
        readAck = 1'b1;
      end else if (respMode == 2) begin
        readAck = 1'bx;
      end else begin
        if (readReq === 1'b1) reqCount++;
        else reqCount = 0;
        if (reqCount == 2) begin
          readAck = 1'b0;
        end else if (reqCount == 3) begin
          base     = ramAddress;
          ramValue = {mem[8'(base + 8'd3)], mem[8'(base + 8'd2)],
                      mem[8'(base + 8'd1)], mem[base]};
          readAck  = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic poke3(input logic [7:0] addr, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2);
    mem[addr]             = b0;
    mem[8'(addr + 8'd1)]  = b1;
    mem[8'(addr + 8'd2)]  = b2;
  endtask

  task automatic holdReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs the program in memory to HALT; expected end state goes to the scoreboard
  task automatic applyStimulus(input int id, input logic [7:0] expIp,
                               input logic [31:0] expR0, input logic [31:0] expR1,
                               input logic [7:0] expRet, input logic [7:0] expUnk,
                               input int expCycles);
    expect_t e;
    int      cycles;
    bit      halted;
    e.id = id; e.ip = expIp; e.r0 = expR0; e.r1 = expR1;
    e.retired = expRet; e.unknown = expUnk; e.cycles = expCycles;
    sb.push_back(e);
    respMode = 0;
    holdReset();
    cycles = 0;
    halted = 1'b0;
    while (!halted && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
      if (debug[31:24] == 8'h04) halted = 1'b1;
    end
    e = sb.pop_front();
    checkOutput($sformatf("p%0d_halted", e.id), {31'b0, halted}, 32'd1);
    checkOutput($sformatf("p%0d_cycles", e.id), cycles, e.cycles);
    checkOutput($sformatf("p%0d_ip", e.id), {24'h0, iPointer}, {24'h0, e.ip});
    checkOutput($sformatf("p%0d_r0", e.id), r0, e.r0);
    checkOutput($sformatf("p%0d_r1", e.id), r1, e.r1);
    checkOutput($sformatf("p%0d_debug", e.id), debug,
                {8'h04, 8'h00, e.unknown, e.retired});
    checkOutput($sformatf("p%0d_opcode", e.id), {24'h0, opCode}, 32'h07);
  endtask

  initial begin
    int  errs;
    int  waitCycles;
    bit  found;
    vectors     = 0;
    miscompares = 0;
    respMode    = 0;
    reset       = 1'b1;
    clearMem();

    // Power-on values before any clock edge
    #1;
    checkOutput("poweron_ip", {24'h0, iPointer}, 32'h0);
    checkOutput("poweron_req", {31'b0, readReq}, 32'h0);
    checkOutput("poweron_debug", debug, 32'h0);
    checkOutput("poweron_r0", r0, 32'h0);

    // Reset values after an edge
    @(posedge clk);
    #1;
    checkOutput("reset_ip", {24'h0, iPointer}, 32'h0);
    checkOutput("reset_addr", {24'h0, ramAddress}, 32'h0);
    checkOutput("reset_debug", debug, 32'h0);

    // MOVC, MOVC, ADD, HALT
    clearMem();
    poke3(8'h00, 8'h01, 8'h00, 8'h2A);
    poke3(8'h03, 8'h01, 8'h01, 8'h05);
    poke3(8'h06, 8'h03, 8'h00, 8'h01);
    mem[8'h09] = 8'h07;
    applyStimulus(1, 8'h09, 32'h0000002F, 32'h00000005, 8'd4, 8'h00, 21);

    // JMP then HALT; no requests after halting
    clearMem();
    poke3(8'h00, 8'h05, 8'h10, 8'h00);
    mem[8'h10] = 8'h07;
    applyStimulus(2, 8'h10, 32'h0, 32'h0, 8'd2, 8'h00, 11);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (readReq !== 1'b0 || iPointer !== 8'h10) errs++;
    end
    checkOutput("p2_quiet_after_halt", errs, 0);

    // LOAD from 0x20
    clearMem();
    poke3(8'h00, 8'h04, 8'h00, 8'h20);
    mem[8'h03] = 8'h07;
    mem[8'h20] = 8'h78; mem[8'h21] = 8'h56; mem[8'h22] = 8'h34; mem[8'h23] = 8'h12;
    applyStimulus(3, 8'h03, 32'h12345678, 32'h0, 8'd2, 8'h00, 15);

    // JZ taken with r1 = 0
    clearMem();
    poke3(8'h00, 8'h06, 8'h01, 8'h08);
    mem[8'h03] = 8'h07;
    mem[8'h08] = 8'h07;
    applyStimulus(4, 8'h08, 32'h0, 32'h0, 8'd2, 8'h00, 11);

    // JZ not taken with r1 = 1
    clearMem();
    poke3(8'h00, 8'h01, 8'h01, 8'h01);
    poke3(8'h03, 8'h06, 8'h01, 8'h08);
    mem[8'h06] = 8'h07;
    mem[8'h08] = 8'h07;
    applyStimulus(5, 8'h06, 32'h0, 32'h1, 8'd3, 8'h00, 16);

    // Unknown opcode behaves as NOP and is recorded
    clearMem();
    mem[8'h00] = 8'hFF;
    mem[8'h01] = 8'h07;
    applyStimulus(6, 8'h01, 32'h0, 32'h0, 8'd2, 8'hFF, 11);

    // ip wraps FE -> FF -> 00 across two NOPs; JZ both ways on r0
    clearMem();
    poke3(8'h00, 8'h06, 8'h00, 8'h10);
    mem[8'h03] = 8'h07;
    poke3(8'h10, 8'h01, 8'h00, 8'h01);
    poke3(8'h13, 8'h05, 8'hFE, 8'h00);
    applyStimulus(7, 8'h03, 32'h1, 32'h0, 8'd7, 8'h00, 36);

    // MOV and ADD of a register to itself
    clearMem();
    poke3(8'h00, 8'h01, 8'h01, 8'h07);
    poke3(8'h03, 8'h02, 8'h00, 8'h01);
    poke3(8'h06, 8'h03, 8'h00, 8'h00);
    mem[8'h09] = 8'h07;
    applyStimulus(8, 8'h09, 32'h0000000E, 32'h7, 8'd4, 8'h00, 21);

    // ADD wraps modulo 2^32
    clearMem();
    poke3(8'h00, 8'h04, 8'h00, 8'h20);
    poke3(8'h03, 8'h01, 8'h01, 8'h02);
    poke3(8'h06, 8'h03, 8'h00, 8'h01);
    mem[8'h09] = 8'h07;
    mem[8'h20] = 8'hFF; mem[8'h21] = 8'hFF; mem[8'h22] = 8'hFF; mem[8'h23] = 8'hFF;
    applyStimulus(9, 8'h09, 32'h1, 32'h2, 8'd4, 8'h00, 25);

    // Ack stuck high, then stuck X: never accepted, core waits in FETCH
    for (int m = 1; m <= 2; m++) begin
      respMode = m;
      holdReset();
      repeat (30) @(posedge clk);
      #1;
      checkOutput($sformatf("stuck%0d_state", m), {24'h0, debug[31:24]}, 32'h1);
      checkOutput($sformatf("stuck%0d_req", m), {31'b0, readReq}, 32'h1);
      checkOutput($sformatf("stuck%0d_retired", m), {24'h0, debug[7:0]}, 32'h0);
    end

    // Reset asserted mid-FETCH, after two instructions have retired
    clearMem();
    poke3(8'h00, 8'h01, 8'h00, 8'h2A);
    poke3(8'h03, 8'h01, 8'h01, 8'h05);
    poke3(8'h06, 8'h03, 8'h00, 8'h01);
    mem[8'h09] = 8'h07;
    respMode = 0;
    holdReset();
    found = 1'b0;
    waitCycles = 0;
    while (!found && waitCycles < 100) begin
      @(posedge clk);
      #1;
      waitCycles++;
      if (debug[7:0] == 8'd2 && readReq === 1'b1) found = 1'b1;
    end
    checkOutput("midfetch_reached", {31'b0, found}, 32'd1);
    checkOutput("midfetch_addr", {24'h0, ramAddress}, 32'h06);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_ip", {24'h0, iPointer}, 32'h0);
    checkOutput("midreset_op", {24'h0, opCode}, 32'h0);
    checkOutput("midreset_r0", r0, 32'h0);
    checkOutput("midreset_r1", r1, 32'h0);
    checkOutput("midreset_debug", debug, 32'h0);
    checkOutput("midreset_addr", {24'h0, ramAddress}, 32'h0);
    checkOutput("midreset_req", {31'b0, readReq}, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
